write_pointer_full: RTL and testbench
=====================================

// Module: write_pointer_full
// PURPOSE
//  Write-domain pointer and full-flag stage of the async FIFO. Consumes the Gray read pointer already
//  synchronised into write_clk, owns the write binary/Gray counters, and produces the memory write
//  address, the Gray write pointer (sent to the read-domain synchroniser), full, fill level, overflow.
// PARAMETERS
//  address_size      4   FIFO depth = 2**address_size; pointers are address_size+1 bits (wrap bit). Legal >=2.
//  almost_full_margin 2  almost_full asserts when level >= 2**address_size - almost_full_margin. Legal 1..depth.
// PORTS
//  write_clk        in   1                write-domain clock
//  wreset_n         in   1                asynchronous active-low reset
//  write_en         in   1                write request from producer
//  clear_overflow   in   1                clears sticky write_overflow
//  read_pointer_s   in   address_size+1   Gray read pointer, already synchronised to write_clk
//  write_addr       out  address_size     RAM write address (binary, low bits of counter)
//  write_pointer    out  address_size+1   Gray write pointer, registered, to read-side synchroniser
//  write_full       out  1                FIFO full, registered
//  write_level      out  address_size+1   entries occupied as seen by write side, 0..2**address_size
//  write_overflow   out  1                sticky: write attempted while full
//  write_almost_full out 1                threshold flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (wreset_n low, async, no clock needed): wbin=0, write_pointer=0, write_addr=0, write_full=0,
//    write_level=0, write_overflow=0, write_almost_full=0.
//  - Accept = write_en & ~write_full. On accept wbin_next = wbin+1 (mod 2**(address_size+1)), else wbin.
//  - write_pointer registered as wgray_next = (wbin_next>>1)^wbin_next; no combinational path to output.
//  - write_addr = wbin[address_size-1:0]; data for the accepted write goes to that address this cycle.
//  - write_full registered: wgray_next == {~read_pointer_s[AS:AS-1], read_pointer_s[AS-2:0]}.
//    Full asserts on the edge of the accepting write that fills the FIFO (zero extra latency).
//  - Full release: one write_clk after read_pointer_s changes (sync latency is upstream, pessimistic-safe).
//  - write_level registered: (wbin_next - gray2bin(read_pointer_s)) mod 2**(AS+1); same edge as write_full.
//  - write_en while write_full: pointers unchanged, no RAM write, write_overflow <= 1 next edge.
//  - write_overflow stays 1 until clear_overflow; simultaneous set and clear -> set wins.
//  - Wrap-around: counter wraps naturally; MSB toggle distinguishes full from empty; no special case.
//  - read_pointer_s equal to write_pointer -> level 0; full never asserts with write_en low.
//  - Reset mid-operation: everything returns to reset values immediately; first post-reset write
//    goes to address 0.
// CONFIGURATION
//  Macro WRITE_ALMOST_FULL_EN:
//   defined     -> write_almost_full registered, = (level_next >= 2**address_size - almost_full_margin),
//                  asserts/deasserts on the same edge as write_level updates.
//   not defined -> write_almost_full tied 0; threshold comparator not built; port list unchanged.
// STRUCTURE
//  - Shared package fifo_pkg: functions bin2gray/gray2bin parameterised by width, and
//    localparam-style helpers for depth (2**address_size) reused by the read-side empty stage.
//  - One sub-module: gray_to_binary (XOR prefix chain, combinational) converting read_pointer_s
//    for the level subtractor; the read-empty stage instantiates the same module.
//  - Everything else flat: counter, Gray register, full compare, level, overflow, optional almost_full.
// TESTING  (address_size=4, almost_full_margin=2, WRITE_ALMOST_FULL_EN defined unless noted)
//  1. Hold wreset_n=0, toggle inputs -> all outputs 0; release, idle -> outputs stay 0.
//  2. read_pointer_s=0, 16 consecutive writes -> after 16th edge write_full=1, write_level=16,
//     write_pointer=5'b11000, write_addr=0; write_almost_full rises on edge where level becomes 14.
//  3. Full, write_en=1 for 3 cycles -> write_pointer holds 5'b11000, write_overflow=1 and stays;
//     pulse clear_overflow -> 0; clear and overflow same cycle -> remains 1.
//  4. Full, set read_pointer_s=gray(4)=5'b00110 -> next edge write_full=0, write_level=12, almost_full=0.
//  5. Streaming 40 writes with read_pointer_s trailing by 3 -> write_addr wraps 15->0, write_pointer
//     passes gray(31)=5'b10000 -> 5'b00000, write_full never asserts, level constant 3/4.
//  6. Assert wreset_n mid-burst at count 7 (between edges) -> outputs 0 without a clock edge;
//     macro undefined build: repeat test 2, write_almost_full constantly 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: helpers shared by the write-full and read-empty pointer stages
// of the async FIFO.
//   bin2gray / gray2bin : width-agnostic conversions. Callers zero-extend
//                         into 32 bits and slice the result. Zero upper bits
//                         do not disturb either conversion.
//   fifo_depth          : 2**address_size, for localparams on both sides.
package fifo_pkg;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] r;
        r = g;
        for (int i = 30; i >= 0; i--) r[i] = r[i+1] ^ g[i];
        return r;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned address_size);
        return 32'd1 << address_size;
    endfunction

endpackage

// File: rtl/gray_to_binary.sv
// gray_to_binary: combinational Gray-to-binary converter. It is built as an
// XOR prefix chain that runs from the MSB down. The read-empty stage uses
// the same module.
//   width : pointer width
//   gray  : Gray-coded input
//   bin   : binary output
module gray_to_binary #(
    parameter int width = 5
) (
    input  logic [width-1:0] gray,
    output logic [width-1:0] bin
);

    assign bin[width-1] = gray[width-1];

    for (genvar i = width - 2; i >= 0; i--) begin : g_chain
        assign bin[i] = bin[i+1] ^ gray[i];
    end

endmodule

// File: rtl/write_pointer_full.sv
// write_pointer_full: write-domain pointer and full-flag stage of the async FIFO.
// This stage owns the binary and Gray write counters. It compares against the
// synchronised Gray read pointer to produce full, fill level and a sticky
// overflow flag.
//   write_clk, wreset_n : clock, async active-low reset
//   write_en            : producer write request
//   clear_overflow      : clears write_overflow (a same-cycle set wins)
//   read_pointer_s      : Gray read pointer, already in write_clk domain
//   write_addr          : RAM write address for the current accepted write
//   write_pointer       : registered Gray write pointer to read-side sync
//   write_full          : registered full flag
//   write_level         : occupancy as seen from write side, 0..depth
//   write_overflow      : sticky, write attempted while full
//   write_almost_full   : level >= depth - almost_full_margin, registered.
//                         Built only when WRITE_ALMOST_FULL_EN is defined.
//                         Otherwise it is tied to 0.
module write_pointer_full
    import fifo_pkg::*;
#(
    parameter int address_size       = 4,
    parameter int almost_full_margin = 2
) (
    input  logic                  write_clk,
    input  logic                  wreset_n,
    input  logic                  write_en,
    input  logic                  clear_overflow,
    input  logic [address_size:0] read_pointer_s,
    output logic [address_size-1:0] write_addr,
    output logic [address_size:0] write_pointer,
    output logic                  write_full,
    output logic [address_size:0] write_level,
    output logic                  write_overflow,
    output logic                  write_almost_full
);

    localparam int          AS    = address_size;
    localparam int          PW    = address_size + 1;
    localparam int unsigned DEPTH = fifo_depth(address_size);

    if (address_size < 2 || almost_full_margin < 1 || almost_full_margin > int'(DEPTH)) begin : g_bad_param
        $error("write_pointer_full: illegal address_size/almost_full_margin");
    end

    logic [PW-1:0] wbin, wbin_next, wgray_next, rbin, level_next;
    logic          accept, full_next;

    gray_to_binary #(.width(PW)) u_rptr_g2b (
        .gray (read_pointer_s),
        .bin  (rbin)
    );

    assign accept     = write_en & ~write_full;
    assign wbin_next  = accept ? wbin + PW'(1) : wbin;
    assign wgray_next = PW'(bin2gray(32'(wbin_next)));

    // The write pointer is full when it is exactly one lap ahead of the read
    // pointer. In Gray code that means the top two bits are inverted and the
    // rest are equal.
    assign full_next  = (wgray_next == {~read_pointer_s[AS:AS-1], read_pointer_s[AS-2:0]});
    assign level_next = wbin_next - rbin;
    assign write_addr = wbin[AS-1:0];

    always_ff @(posedge write_clk or negedge wreset_n) begin
        if (!wreset_n) begin
            wbin           <= '0;
            write_pointer  <= '0;
            write_full     <= 1'b0;
            write_level    <= '0;
            write_overflow <= 1'b0;
        end else begin
            wbin          <= wbin_next;
            write_pointer <= wgray_next;
            write_full    <= full_next;
            write_level   <= level_next;
            if (write_en && write_full)
                write_overflow <= 1'b1;
            else if (clear_overflow)
                write_overflow <= 1'b0;
        end
    end

`ifdef WRITE_ALMOST_FULL_EN
    localparam int unsigned AF_THRESH = DEPTH - almost_full_margin;

    always_ff @(posedge write_clk or negedge wreset_n) begin
        if (!wreset_n)
            write_almost_full <= 1'b0;
        else
            write_almost_full <= (level_next >= PW'(AF_THRESH));
    end
`else
    assign write_almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_write_pointer_full.sv
// tb_write_pointer_full: randomized and directed bench for write_pointer_full
// with address_size=4 and almost_full_margin=2. The reference model tracks
// unwrapped write and read counts as plain integers. It derives level, full,
// overflow and almost_full from those counts.
module tb_write_pointer_full;

    localparam int AS = 4;
    localparam int DEPTH = 16;
    localparam int MARGIN = 2;

    logic          write_clk = 1'b0;
    logic          wreset_n;
    logic          write_en;
    logic          clear_overflow;
    logic [AS:0]   read_pointer_s;
    logic [AS-1:0] write_addr;
    logic [AS:0]   write_pointer;
    logic          write_full;
    logic [AS:0]   write_level;
    logic          write_overflow;
    logic          write_almost_full;

    write_pointer_full #(.address_size(AS), .almost_full_margin(MARGIN)) dut (
        .write_clk         (write_clk),
        .wreset_n          (wreset_n),
        .write_en          (write_en),
        .clear_overflow    (clear_overflow),
        .read_pointer_s    (read_pointer_s),
        .write_addr        (write_addr),
        .write_pointer     (write_pointer),
        .write_full        (write_full),
        .write_level       (write_level),
        .write_overflow    (write_overflow),
        .write_almost_full (write_almost_full)
    );

    always #5 write_clk = ~write_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model state. wcnt and rcnt are unwrapped counts of accepted writes and reads.
    int wcnt, rcnt;
    bit m_full, m_ovf;
    int m_lvl;

`ifdef WRITE_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [AS:0] gray_of(input int n);
        int b;
        b = n % 32;
        return 5'((b >> 1) ^ b);
    endfunction

    task automatic set_rd(input int n);
        rcnt = n;
        read_pointer_s = gray_of(n);
    endtask

    task automatic model_reset();
        wcnt = 0; m_full = 0; m_ovf = 0; m_lvl = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".addr"},  32'(write_addr),     32'(wcnt % DEPTH));
        chk({tag, ".ptr"},   32'(write_pointer),  32'(gray_of(wcnt)));
        chk({tag, ".full"},  32'(write_full),     32'(m_full));
        chk({tag, ".level"}, 32'(write_level),    32'(m_lvl));
        chk({tag, ".ovf"},   32'(write_overflow), 32'(m_ovf));
        chk({tag, ".af"},    32'(write_almost_full), 32'(AF_EN && m_lvl >= DEPTH - MARGIN));
    endtask

    // One clock. The model is updated from the inputs that were present at
    // the edge. All outputs are then checked 1 ns later.
    task automatic cyc(input string tag);
        @(posedge write_clk);
        if (!wreset_n) model_reset();
        else begin
            if (write_en && m_full) m_ovf = 1;
            else if (clear_overflow) m_ovf = 0;
            if (write_en && !m_full) wcnt++;
            m_lvl  = wcnt - rcnt;
            m_full = (m_lvl == DEPTH);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        wreset_n = 0; write_en = 0; clear_overflow = 0; set_rd(0);
        model_reset();
        #2;
        check_all("reset_async");

        // 1: inputs toggled while held in reset
        for (int i = 0; i < 4; i++) begin
            write_en = 1'($urandom); clear_overflow = 1'($urandom);
            read_pointer_s = 5'($urandom);
            cyc("in_reset");
        end
        write_en = 0; clear_overflow = 0; set_rd(0);
        wreset_n = 1;
        for (int i = 0; i < 3; i++) cyc("idle");

        // 2: fill from empty
        write_en = 1;
        for (int i = 0; i < 16; i++) cyc("fill");
        chk("fill.full_const", 32'(write_full), 32'd1);
        chk("fill.lvl_const",  32'(write_level), 32'd16);
        chk("fill.ptr_const",  32'(write_pointer), 32'b11000);
        chk("fill.addr_const", 32'(write_addr), 32'd0);

        // 3: overflow sticky, clear, and a simultaneous set and clear
        for (int i = 0; i < 3; i++) cyc("ovf");
        chk("ovf.ptr_const", 32'(write_pointer), 32'b11000);
        chk("ovf.flag_const", 32'(write_overflow), 32'd1);
        write_en = 0; cyc("ovf_hold");
        clear_overflow = 1; cyc("ovf_clr");
        chk("ovf.cleared", 32'(write_overflow), 32'd0);
        write_en = 1; cyc("ovf_setclr");
        chk("ovf.set_wins", 32'(write_overflow), 32'd1);
        write_en = 0; clear_overflow = 1; cyc("ovf_clr2");
        clear_overflow = 0;

        // 4: reader frees 4 entries
        set_rd(4); cyc("release");
        chk("rel.full", 32'(write_full), 32'd0);
        chk("rel.level", 32'(write_level), 32'd12);

        // 5: streaming with the reader trailing by 3 (crosses both wraps)
        write_en = 1;
        set_rd(wcnt - 3 + 1);
        for (int i = 0; i < 40; i++) begin
            cyc("stream");
            set_rd(wcnt - 3);
        end

        // Randomized traffic. Read bias alternates between phases so the
        // FIFO repeatedly fills and drains.
        for (int ph = 0; ph < 8; ph++) begin
            for (int i = 0; i < 150; i++) begin
                write_en = ($urandom_range(3, 0) != 0) ^ (ph[0] & ($urandom_range(1, 0) == 1'b1));
                clear_overflow = ($urandom_range(7, 0) == 0);
                cyc("rand");
                if (wcnt > rcnt && $urandom_range(ph[0] ? 1 : 4, 0) == 0)
                    set_rd(rcnt + $urandom_range(wcnt - rcnt, 1));
            end
        end

        // 6: async reset mid-burst, asserted between edges
        write_en = 0; clear_overflow = 1; cyc("pre_rst");
        set_rd(wcnt); cyc("pre_rst2");
        clear_overflow = 0; write_en = 1;
        for (int i = 0; i < 7; i++) cyc("burst");
        #2 wreset_n = 0;
        #1;
        model_reset();
        check_all("mid_rst");
        write_en = 0; set_rd(0);
        cyc("mid_rst_hold");
        wreset_n = 1;
        write_en = 1; cyc("post_rst");
        chk("post_rst.addr1", 32'(write_addr), 32'd1);
        write_en = 0; cyc("post_rst_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
